// File: rtl/dmem_store_buffer_if.sv
// CPU-side and memory-side signal bundle for the data-memory store buffer.
// The buffer takes the slave view; the CPU/memory environment takes the master view.
interface dmem_store_buffer_if #(
   parameter int AW = 6,
   parameter int DW = 16
);
   logic          cpu_wr_en;
   logic          cpu_rd_en;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   logic          mem_wr_en;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          empty;

   modport slave (
      input  cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata, mem_rdata,
      output cpu_rdata, cpu_stall, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, empty
   );

   modport master (
      output cpu_wr_en, cpu_rd_en, cpu_addr, cpu_wdata, mem_rdata,
      input  cpu_rdata, cpu_stall, mem_wr_en, mem_rd_en, mem_addr, mem_wdata, empty
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write FIFO between the core and data memory: stores retire when the port is idle,
// loads have port priority and are forwarded from the newest matching buffered store.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 6,
   parameter int DW    = 16
) (
   input logic                clk,
   input logic                rst,
   dmem_store_buffer_if.slave bus
);
   localparam int          PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [AW-1:0] addrMem_q [DEPTH];
   logic [DW-1:0] dataMem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [PW:0]   count_q, count_d;

   logic          isFull;
   logic          accept;
   logic          drain;
   logic          fwdHit;
   logic [DW-1:0] fwdData;

   assign isFull = (count_q == FULL);
   assign accept = !rst && bus.cpu_wr_en && !isFull;
   assign drain  = !rst && !bus.cpu_rd_en && (count_q != '0);

   // Walk oldest to newest so the last match seen is the newest store to that address.
   always_comb begin
      fwdHit  = 1'b0;
      fwdData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (((PW+1)'(i) < count_q) && (addrMem_q[rdPtr_q + PW'(i)] == bus.cpu_addr)) begin
            fwdHit  = 1'b1;
            fwdData = dataMem_q[rdPtr_q + PW'(i)];
         end
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (accept) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (drain) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      if (accept && !drain) begin
         count_d = count_q + 1'b1;
      end else if (!accept && drain) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Entry contents need no reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (accept) begin
         addrMem_q[wrPtr_q] <= bus.cpu_addr;
         dataMem_q[wrPtr_q] <= bus.cpu_wdata;
      end
   end

   assign bus.cpu_stall = !rst && bus.cpu_wr_en && isFull;
   assign bus.mem_rd_en = !rst && bus.cpu_rd_en;
   assign bus.mem_wr_en = drain;
   assign bus.mem_addr  = bus.mem_rd_en ? bus.cpu_addr :
                          drain         ? addrMem_q[rdPtr_q] : '0;
   assign bus.mem_wdata = drain ? dataMem_q[rdPtr_q] : '0;
   assign bus.cpu_rdata = !bus.mem_rd_en ? '0 :
                          fwdHit         ? fwdData : bus.mem_rdata;
   assign bus.empty     = rst || (count_q == '0);
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed bench for dmem_store_buffer with a behavioural data memory that logs every write.
// Inputs change 1 ns after a rising edge and outputs are sampled 1 ns later.
module tb_dmem_store_buffer;
   localparam int AW    = 6;
   localparam int DW    = 16;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   base;

   logic [DW-1:0] memArr  [64];
   logic [AW-1:0] logAddr [256];
   logic [DW-1:0] logData [256];
   int            writeCnt = 0;

   dmem_store_buffer_if #(.AW(AW), .DW(DW)) bus ();

   dmem_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.mem_rdata = bus.mem_rd_en ? memArr[bus.mem_addr] : '0;

   // Memory clears to zero under reset with a few preset words, and records each write in order.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) memArr[i] <= '0;
         memArr[7]  <= 16'h0042;
         memArr[40] <= 16'h5A5A;
         memArr[10] <= 16'hF00A;
         memArr[11] <= 16'hF00B;
         memArr[12] <= 16'hF00C;
         memArr[13] <= 16'hF00D;
      end else if (bus.mem_wr_en) begin
         memArr[bus.mem_addr]  <= bus.mem_wdata;
         logAddr[writeCnt[7:0]] <= bus.mem_addr;
         logData[writeCnt[7:0]] <= bus.mem_wdata;
         writeCnt <= writeCnt + 1;
      end
   end

   // Drives one cycle of CPU inputs and leaves time for combinational outputs to settle.
   task automatic applyStimulus(input logic r, input logic wr, input logic rd,
                                input logic [AW-1:0] a, input logic [DW-1:0] d);
      @(posedge clk);
      #1;
      rst           = r;
      bus.cpu_wr_en = wr;
      bus.cpu_rd_en = rd;
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      #1;
   endtask

   // Compares one observed value to its expected value and tallies the result.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Directed sequence: reset, forwarding order, full/stall, load priority, load+store, wrap.
   initial begin
      bus.cpu_wr_en = 1'b1;
      bus.cpu_rd_en = 1'b1;
      bus.cpu_addr  = 6'd5;
      bus.cpu_wdata = 16'h1234;

      applyStimulus(1'b1, 1'b1, 1'b1, 6'd5, 16'h1234);
      checkOutput("rst stall",   bus.cpu_stall, 1'b0);
      checkOutput("rst mem_wr",  bus.mem_wr_en, 1'b0);
      checkOutput("rst mem_rd",  bus.mem_rd_en, 1'b0);
      checkOutput("rst rdata",   bus.cpu_rdata, 16'h0000);
      checkOutput("rst empty",   bus.empty,     1'b1);

      base = writeCnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd5, 16'h1111);
      checkOutput("st5 stall",   bus.cpu_stall, 1'b0);
      checkOutput("st5 mem_wr",  bus.mem_wr_en, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("rst2 mem_wr", bus.mem_wr_en, 1'b0);
      checkOutput("rst2 empty",  bus.empty,     1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd5, 16'h0000);
      checkOutput("ld5 rdata",   bus.cpu_rdata, 16'h0000);
      checkOutput("ld5 empty",   bus.empty,     1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("post rst mem_wr", bus.mem_wr_en, 1'b0);
      checkOutput("post rst writes", writeCnt - base, 0);

      base = writeCnt;
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd3, 16'hAAAA);
      checkOutput("stA mem_wr",  bus.mem_wr_en, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd3, 16'hBBBB);
      checkOutput("stB mem_wr",  bus.mem_wr_en, 1'b1);
      checkOutput("stB addr",    bus.mem_addr,  6'd3);
      checkOutput("stB wdata",   bus.mem_wdata, 16'hAAAA);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd3, 16'h0000);
      checkOutput("fwd rdata",   bus.cpu_rdata, 16'hBBBB);
      checkOutput("fwd mem_wr",  bus.mem_wr_en, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("drB wdata",   bus.mem_wdata, 16'hBBBB);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("fwd empty",   bus.empty,     1'b1);
      checkOutput("fwd nwrites", writeCnt - base, 2);
      checkOutput("fwd log0",    logData[base[7:0]],      16'hAAAA);
      checkOutput("fwd log1",    logData[8'(base + 1)],   16'hBBBB);
      checkOutput("fwd mem3",    memArr[3], 16'hBBBB);

      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, AW'(10 + k), DW'(k + 1));
         checkOutput("fill rdata",  bus.cpu_rdata, 32'hF00A + k);
         checkOutput("fill stall",  bus.cpu_stall, 1'b0);
         checkOutput("fill mem_wr", bus.mem_wr_en, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd14, 16'h0005);
      checkOutput("full stall",  bus.cpu_stall, 1'b1);
      checkOutput("full mem_wr", bus.mem_wr_en, 1'b1);
      checkOutput("full addr",   bus.mem_addr,  6'd10);
      checkOutput("full wdata",  bus.mem_wdata, 16'h0001);
      applyStimulus(1'b0, 1'b1, 1'b0, 6'd14, 16'h0005);
      checkOutput("retry stall", bus.cpu_stall, 1'b0);
      checkOutput("retry addr",  bus.mem_addr,  6'd11);
      checkOutput("retry wdata", bus.mem_wdata, 16'h0002);
      for (int k = 0; k < 10 && bus.empty !== 1'b1; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      end
      checkOutput("full drained", bus.empty, 1'b1);
      for (int k = 0; k < 5; k++) begin
         checkOutput("full mem", memArr[10 + k], k + 1);
      end

      applyStimulus(1'b0, 1'b1, 1'b1, 6'd20, 16'h2020);
      applyStimulus(1'b0, 1'b1, 1'b1, 6'd21, 16'h2121);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd40, 16'h0000);
      checkOutput("miss rdata",  bus.cpu_rdata, 16'h5A5A);
      checkOutput("miss mem_wr", bus.mem_wr_en, 1'b0);
      checkOutput("miss empty",  bus.empty,     1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("miss dr0 wr",   bus.mem_wr_en, 1'b1);
      checkOutput("miss dr0 addr", bus.mem_addr,  6'd20);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("miss dr1 addr",  bus.mem_addr,  6'd21);
      checkOutput("miss dr1 wdata", bus.mem_wdata, 16'h2121);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("miss empty end", bus.empty,     1'b1);
      checkOutput("miss idle wr",   bus.mem_wr_en, 1'b0);

      applyStimulus(1'b0, 1'b1, 1'b1, 6'd7, 16'h9999);
      checkOutput("ldst old",    bus.cpu_rdata, 16'h0042);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd7, 16'h0000);
      checkOutput("ldst new",    bus.cpu_rdata, 16'h9999);
      checkOutput("ldst mem_wr", bus.mem_wr_en, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("ldst drain",  bus.mem_wdata, 16'h9999);
      applyStimulus(1'b0, 1'b0, 1'b1, 6'd7, 16'h0000);
      checkOutput("ldst memrd",  bus.cpu_rdata, 16'h9999);
      checkOutput("ldst empty",  bus.empty,     1'b1);

      for (int i = 0; i < 12; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, AW'(i), DW'(16'h0100 + i));
         checkOutput("wrap st wr",  bus.mem_wr_en, 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
         checkOutput("wrap dr wr",    bus.mem_wr_en, 1'b1);
         checkOutput("wrap dr addr",  bus.mem_addr,  i);
         checkOutput("wrap dr wdata", bus.mem_wdata, 32'h0100 + i);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'h0000);
      checkOutput("wrap empty", bus.empty, 1'b1);
      for (int i = 0; i < 12; i++) begin
         checkOutput("wrap mem", memArr[i], 32'h0100 + i);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
